dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data memory between two requesters:
//   port 0 is the CPU load/store stage, port 1 is the DMA/debug loader.
//   Arbitrates, sequences each access through an IDLE/ISSUE/WAIT FSM and
//   returns read data to the owner with req/gnt/rvalid handshakes.
//   Sits between the requesters and the DMEM array; the array has 1-cycle read latency.
// PARAMETERS
//   DMEM_SIZE   1024  data memory depth in 32-bit words; must be a power of two
//   AW          10    memory address width; log2(DMEM_SIZE)
//   FIXED_PRIO  0     0 = round-robin; 1 = port 0 always wins a conflict
// PORTS
//   CLK        in   1   clock; all state updates on the rising edge
//   RST        in   1   reset, asynchronous, active-high
//   req0       in   1   port 0 access request; hold with fields stable until gnt0
//   we0        in   1   port 0 write (1) / read (0)
//   addr0      in   32  port 0 word address; only [AW-1:0] is used
//   wdata0     in   32  port 0 write data
//   gnt0       out  1   1-cycle pulse: port 0 access issued to memory
//   rvalid0    out  1   1-cycle pulse: rdata0 holds port 0 read result
//   rdata0     out  32  port 0 read data; holds until the next rvalid0
//   req1/we1/addr1/wdata1/gnt1/rvalid1/rdata1   as port 0, for port 1
//   mem_en     out  1   memory access strobe
//   mem_we     out  1   memory write enable; qualified by mem_en
//   mem_adr    out  AW  memory word address
//   mem_wdata  out  32  memory write data
//   mem_rdata  in   32  memory read data; valid the cycle after mem_en with mem_we=0
// BEHAVIOUR
// - Reset (async, RST=1): state=IDLE, owner=0, last=1 (port 0 wins first);
//   gnt*, rvalid*, mem_en, mem_we = 0; mem_adr, mem_wdata, rdata* = 0.
//   Reset mid-access aborts it: no gnt, no rvalid, pending read data is discarded.
// - FSM
//   IDLE : sample req0/req1.
//          None -> stay in IDLE.
//          Otherwise pick owner, latch we/addr[AW-1:0]/wdata, go to ISSUE.
//   ISSUE: mem_en=1, mem_we/mem_adr/mem_wdata from the latch, gnt<owner>=1.
//          Write -> IDLE.  Read -> WAIT.
//   WAIT : register mem_rdata into rdata<owner>.
//          rvalid<owner>=1 in the following cycle.  Go to IDLE.
// - Outputs are registered and driven from the current state.
//   All outputs are 0 outside the cycles listed above.
// - Latency, request seen at cycle N in IDLE:
//   gnt at N+1.  Write lands in memory at the end of N+1.
//   Read: rvalid/rdata at N+3.
//   The IDLE at N+3 can accept the next request, so back-to-back reads
//   complete every 3 cycles and writes every 2.
// - Arbitration, only when both ports request in IDLE:
//   FIXED_PRIO=0: the port != last wins.
//   FIXED_PRIO=1: port 0 wins.
//   last is updated to the owner on every grant.
// - Requests are sampled only in IDLE; req during ISSUE/WAIT is not lost, only deferred.
//   Once latched, an access completes even if req drops before gnt.
// - Address wrap: only addr[AW-1:0] is used (addr 1029 -> mem_adr 5);
//   upper bits are ignored and no error is raised.
// - Read-after-write by the other port sees the new data (the write completes first).
// TESTING
// 1. Port 0 write addr 5 = 0xDEADBEEF, then read addr 5 -> gnt0 at N+1; rvalid0 at N+3; rdata0=0xDEADBEEF.
// 2. req0 and req1 held high for 6 grants, FIXED_PRIO=0 -> grant order 0,1,0,1,0,1; no lost request.
// 3. Same stimulus with FIXED_PRIO=1 -> all grants to port 0; gnt1 only after req0 drops.
// 4. Port 1 write addr 0x405 data 0x1234 -> mem_adr=0x005, mem_we=1; read addr 5 returns 0x1234.
// 5. RST asserted during WAIT of a port 1 read -> outputs 0 immediately; rvalid1 never pulses; FSM is IDLE after release.
// 6. Port 0 read with req0 dropped the cycle after sampling -> gnt0 and rvalid0 still occur with correct data.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter sharing the single-port data memory
// Port 0 is the CPU load/store stage, port 1 the DMA/debug loader.
module dmem_arbiter #(
  parameter int DMEM_SIZE  = 1024,
  parameter int AW         = 10,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req0,
  input  logic          we0,
  input  logic [31:0]   addr0,
  input  logic [31:0]   wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [31:0]   rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [31:0]   addr1,
  input  logic [31:0]   wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [31:0]   rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [AW-1:0] ADR_MASK = AW'(DMEM_SIZE - 1);

  state_t        state, state_nxt;
  logic          owner;
  logic          last;
  logic          pick;
  logic          lat_we;
  logic [AW-1:0] lat_adr;
  logic [31:0]   lat_wdata;
  logic          unused_addr_hi;

  // Upper address bits wrap silently into the memory depth.
  assign unused_addr_hi = ^{addr0[31:AW], addr1[31:AW]};

  always_comb begin
    pick = 1'b0;
    if (req0 && req1) pick = FIXED_PRIO ? 1'b0 : !last;
    else if (req1)    pick = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      lat_we    <= 1'b0;
      lat_adr   <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (req0 || req1)) begin
        owner     <= pick;
        last      <= pick;
        lat_we    <= pick ? we1 : we0;
        lat_adr   <= (pick ? addr1[AW-1:0] : addr0[AW-1:0]) & ADR_MASK;
        lat_wdata <= pick ? wdata1 : wdata0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0 || req1) state_nxt = ISSUE;
      ISSUE:   state_nxt = lat_we ? IDLE : WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    if (state == ISSUE) begin
      gnt0      = !owner;
      gnt1      = owner;
      mem_en    = 1'b1;
      mem_we    = lat_we;
      mem_adr   = lat_adr;
      mem_wdata = lat_wdata;
    end
  end

  // Read data is captured in WAIT and presented with a one-cycle rvalid pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= (state == WAIT) && !owner;
      rvalid1 <= (state == WAIT) && owner;
      if (state == WAIT && !owner) rdata0 <= mem_rdata;
      if (state == WAIT && owner)  rdata1 <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        a_req0 = 0, a_we0 = 0, a_req1 = 0, a_we1 = 0;
  logic [31:0] a_addr0 = 0, a_wdata0 = 0, a_addr1 = 0, a_wdata1 = 0;
  logic        a_gnt0, a_rvalid0, a_gnt1, a_rvalid1, a_mem_en, a_mem_we;
  logic [31:0] a_rdata0, a_rdata1, a_mem_wdata;
  logic [31:0] a_mem_rdata = 0;
  logic [9:0]  a_mem_adr;
  logic [31:0] mem_a [0:1023];

  logic        b_req0 = 0, b_we0 = 0, b_req1 = 0, b_we1 = 0;
  logic [31:0] b_addr0 = 0, b_wdata0 = 0, b_addr1 = 0, b_wdata1 = 0;
  logic        b_gnt0, b_rvalid0, b_gnt1, b_rvalid1, b_mem_en, b_mem_we;
  logic [31:0] b_rdata0, b_rdata1, b_mem_wdata;
  logic [31:0] b_mem_rdata = 0;
  logic [9:0]  b_mem_adr;

  dmem_arbiter #(.DMEM_SIZE(1024), .AW(10), .FIXED_PRIO(1'b0)) dut_a (
    .CLK(clk), .RST(rst),
    .req0(a_req0), .we0(a_we0), .addr0(a_addr0), .wdata0(a_wdata0),
    .gnt0(a_gnt0), .rvalid0(a_rvalid0), .rdata0(a_rdata0),
    .req1(a_req1), .we1(a_we1), .addr1(a_addr1), .wdata1(a_wdata1),
    .gnt1(a_gnt1), .rvalid1(a_rvalid1), .rdata1(a_rdata1),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_adr(a_mem_adr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  dmem_arbiter #(.DMEM_SIZE(1024), .AW(10), .FIXED_PRIO(1'b1)) dut_b (
    .CLK(clk), .RST(rst),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0),
    .gnt0(b_gnt0), .rvalid0(b_rvalid0), .rdata0(b_rdata0),
    .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1),
    .gnt1(b_gnt1), .rvalid1(b_rvalid1), .rdata1(b_rdata1),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_adr(b_mem_adr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle-latency memory array behind instance A.
  always @(posedge clk) begin
    if (a_mem_en) begin
      if (a_mem_we) mem_a[a_mem_adr] <= a_mem_wdata;
      else          a_mem_rdata <= mem_a[a_mem_adr];
    end
  end

  typedef struct {
    int          port;
    logic        we;
    logic [9:0]  adr;
    logic [31:0] wd;
    int          cyc;
  } gexp_t;

  typedef struct {
    int          port;
    logic [31:0] d;
    int          cyc;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int    bq[$];
  gexp_t mg;
  rexp_t mr;
  int    mb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Monitor for instance A: every grant and rvalid is matched against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_gnt0 || a_gnt1) begin
        if (gq.size() == 0) flag("unexpected_gnt");
        else begin
          mg = gq.pop_front();
          chk("gnt_both", {63'd0, a_gnt0 & a_gnt1}, 64'd0);
          chk("gnt_port", {63'd0, a_gnt1}, 64'(mg.port));
          chk("mem_en", {63'd0, a_mem_en}, 64'd1);
          chk("mem_we", {63'd0, a_mem_we}, {63'd0, mg.we});
          chk("mem_adr", {54'd0, a_mem_adr}, {54'd0, mg.adr});
          chk("mem_wdata", {32'd0, a_mem_wdata}, {32'd0, mg.wd});
          if (mg.cyc >= 0) chk("gnt_cycle", 64'(cyc), 64'(mg.cyc));
        end
      end else if (a_mem_en || a_mem_we || a_mem_adr != 10'd0 || a_mem_wdata != 32'd0) begin
        flag("mem_active_without_gnt");
      end
      if (a_rvalid0 || a_rvalid1) begin
        if (rq.size() == 0) flag("unexpected_rvalid");
        else begin
          mr = rq.pop_front();
          chk("rvalid_both", {63'd0, a_rvalid0 & a_rvalid1}, 64'd0);
          chk("rvalid_port", {63'd0, a_rvalid1}, 64'(mr.port));
          chk("rdata", {32'd0, (mr.port == 1) ? a_rdata1 : a_rdata0}, {32'd0, mr.d});
          if (mr.cyc >= 0) chk("rvalid_cycle", 64'(cyc), 64'(mr.cyc));
        end
      end
    end
  end

  // Monitor for instance B (fixed priority): grant order only.
  always @(negedge clk) begin
    if (!rst && (b_gnt0 || b_gnt1)) begin
      if (bq.size() == 0) flag("b_unexpected_gnt");
      else begin
        mb = bq.pop_front();
        chk("b_gnt_both", {63'd0, b_gnt0 & b_gnt1}, 64'd0);
        chk("b_gnt_port", {63'd0, b_gnt1}, 64'(mb));
      end
    end
  end

  task automatic set_port(input int port, input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wd);
    if (port == 0) begin
      a_req0 = req; a_we0 = we; a_addr0 = addr; a_wdata0 = wd;
    end else begin
      a_req1 = req; a_we1 = we; a_addr1 = addr; a_wdata1 = wd;
    end
  endtask

  // Single access on instance A issued in an IDLE cycle; latency is checked.
  task automatic access(input int port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd_exp);
    gexp_t g;
    rexp_t r;
    bit    got = 0;
    @(negedge clk);
    set_port(port, 1'b1, we, addr, wd);
    g.port = port; g.we = we; g.adr = addr[9:0]; g.wd = wd; g.cyc = cyc + 1;
    gq.push_back(g);
    if (!we) begin
      r.port = port; r.d = rd_exp; r.cyc = cyc + 3;
      rq.push_back(r);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((port == 0) ? a_gnt0 : a_gnt1) begin
        got = 1;
        break;
      end
    end
    if (!got) flag("gnt_timeout");
    set_port(port, 1'b0, 1'b0, 32'd0, 32'd0);
    if (!we) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (gq.size() != 0 || rq.size() != 0 || bq.size() != 0); i++)
      @(negedge clk);
    if (gq.size() != 0 || rq.size() != 0 || bq.size() != 0) flag("drain_timeout");
  endtask

  task automatic check_outputs_zero(input string name);
    chk(name, {a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_mem_en, a_mem_we, a_mem_adr,
               a_mem_wdata, a_rdata0 | a_rdata1}, 64'd0);
  endtask

  initial begin
    gexp_t g;
    rexp_t r;
    int    n;
    bit    got;

    repeat (2) @(negedge clk);
    check_outputs_zero("reset_outputs");
    chk("reset_b_outputs", {b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_mem_en, b_mem_we},
        64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Round-robin with both ports held: 0,1,0,1,0,1.
    a_req0 = 1; a_we0 = 1; a_addr0 = 32'd10; a_wdata0 = 32'h0000_00A0;
    a_req1 = 1; a_we1 = 1; a_addr1 = 32'd20; a_wdata1 = 32'h0000_00B1;
    for (int k = 0; k < 6; k++) begin
      g.port = k % 2; g.we = 1'b1; g.cyc = -1;
      g.adr = (k % 2 == 0) ? 10'd10 : 10'd20;
      g.wd  = (k % 2 == 0) ? 32'h0000_00A0 : 32'h0000_00B1;
      gq.push_back(g);
    end
    n = 0;
    for (int i = 0; i < 40 && n < 6; i++) begin
      @(negedge clk);
      if (a_gnt0 || a_gnt1) n++;
    end
    chk("rr_grant_count", 64'(n), 64'd6);
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
    drain();

    // Write then read back on port 0 with exact latency.
    access(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 32'd0);
    access(0, 1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF);
    drain();

    // Port 1 write wraps 0x405 to 5; port 0 reads the new value.
    access(1, 1'b1, 32'h0000_0405, 32'h0000_1234, 32'd0);
    access(0, 1'b0, 32'd5, 32'd0, 32'h0000_1234);
    drain();

    // Port 0 read whose req drops right after being sampled.
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 32'd10, 32'd0);
    g.port = 0; g.we = 1'b0; g.adr = 10'd10; g.wd = 32'd0; g.cyc = cyc + 1;
    gq.push_back(g);
    r.port = 0; r.d = 32'h0000_00A0; r.cyc = cyc + 3;
    rq.push_back(r);
    @(posedge clk);
    #1;
    set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drain();

    // Reset during WAIT of a port 1 read: rvalid1 must never appear.
    @(negedge clk);
    set_port(1, 1'b1, 1'b0, 32'd20, 32'd0);
    g.port = 1; g.we = 1'b0; g.adr = 10'd20; g.wd = 32'd0; g.cyc = cyc + 1;
    gq.push_back(g);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_gnt1) begin
        got = 1;
        break;
      end
    end
    if (!got) flag("reset_test_gnt_timeout");
    set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("reset_mid_wait");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rdata1_after_reset", {32'd0, a_rdata1}, 64'd0);
    access(1, 1'b1, 32'd7, 32'h0000_0077, 32'd0);
    access(1, 1'b0, 32'd20, 32'd0, 32'h0000_00B1);
    drain();

    // Fixed priority: port 0 wins while it requests, then port 1.
    @(negedge clk);
    b_req0 = 1; b_we0 = 1; b_addr0 = 32'd1; b_wdata0 = 32'h11;
    b_req1 = 1; b_we1 = 1; b_addr1 = 32'd2; b_wdata1 = 32'h22;
    bq.push_back(0); bq.push_back(0); bq.push_back(0); bq.push_back(1);
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (b_gnt0 || b_gnt1) n++;
    end
    b_req0 = 0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_gnt0 || b_gnt1) begin
        got = 1;
        break;
      end
    end
    b_req1 = 0;
    chk("fixed_prio_final_gnt_seen", {63'd0, got}, 64'd1);
    drain();
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
